// File: rtl/pc_stack_unit.sv
// Program counter with relative branch, skip-next and a hardware call/return stack.
// Reports stack overflow and underflow through sticky flags.
module pc_stack_unit #(
  parameter int ADDR_W      = 14,
  parameter int OFF_W       = 8,
  parameter int STACK_DEPTH = 8,
  parameter int RESET_VEC   = 0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           update_pc,
  input  logic [2:0]                     op,
  input  logic [ADDR_W-1:0]              jump_addr,
  input  logic [OFF_W-1:0]               rel_offset,
  output logic [ADDR_W-1:0]              PC,
  output logic [$clog2(STACK_DEPTH):0]   stack_depth,
  output logic                           stack_full,
  output logic                           stack_empty,
  output logic                           stack_overflow,
  output logic                           stack_underflow
);

  localparam int PTR_W   = $clog2(STACK_DEPTH);
  localparam int DEPTH_W = PTR_W + 1;

  typedef enum logic [2:0] {
    OP_NEXT   = 3'd0,
    OP_JUMP   = 3'd1,
    OP_BRANCH = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4,
    OP_SKIP   = 3'd5
  } op_e;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;

  logic [ADDR_W-1:0]  stack_mem [STACK_DEPTH];
  logic               push_en;
  logic [PTR_W-1:0]   push_idx;
  logic [PTR_W-1:0]   pop_idx;
  logic [ADDR_W-1:0]  pc_plus1;
  logic [ADDR_W-1:0]  offset_ext;
  logic               full;
  logic               empty;

  assign full       = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign empty      = (depth_q == '0);
  assign pc_plus1   = pc_q + ADDR_W'(1);
  assign offset_ext = ADDR_W'($signed(rel_offset));
  assign push_idx   = depth_q[PTR_W-1:0];
  assign pop_idx    = PTR_W'(depth_q - DEPTH_W'(1));

  always_comb begin
    pc_d        = pc_q;
    depth_d     = depth_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    push_en     = 1'b0;
    if (clear) begin
      pc_d        = ADDR_W'(RESET_VEC);
      depth_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else if (update_pc) begin
      case (op)
        OP_NEXT:   pc_d = pc_plus1;
        OP_JUMP:   pc_d = jump_addr;
        OP_BRANCH: pc_d = pc_q + offset_ext;
        OP_SKIP:   pc_d = pc_q + ADDR_W'(2);
        OP_CALL: begin
          pc_d = jump_addr;
          // A call while full still jumps; only the return address is lost.
          if (full) begin
            overflow_d = 1'b1;
          end else begin
            push_en = 1'b1;
            depth_d = depth_q + DEPTH_W'(1);
          end
        end
        OP_RET: begin
          if (empty) begin
            pc_d        = pc_plus1;
            underflow_d = 1'b1;
          end else begin
            pc_d    = stack_mem[pop_idx];
            depth_d = depth_q - DEPTH_W'(1);
          end
        end
        default:   pc_d = pc_plus1;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q        <= ADDR_W'(RESET_VEC);
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      depth_q     <= depth_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Return-address storage is deliberately left unreset; depth alone defines validity.
  always_ff @(posedge clock) begin
    if (push_en) begin
      stack_mem[push_idx] <= pc_plus1;
    end
  end

  assign PC              = pc_q;
  assign stack_depth     = depth_q;
  assign stack_full      = full;
  assign stack_empty     = empty;
  assign stack_overflow  = overflow_q;
  assign stack_underflow = underflow_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed self-checking bench for pc_stack_unit with the default parameters.
module tb_pc_stack_unit;

  logic        clock;
  logic        reset;
  logic        clear;
  logic        update_pc;
  logic [2:0]  op;
  logic [13:0] jump_addr;
  logic [7:0]  rel_offset;
  logic [13:0] PC;
  logic [3:0]  stack_depth;
  logic        stack_full;
  logic        stack_empty;
  logic        stack_overflow;
  logic        stack_underflow;

  int tests = 0;
  int fails = 0;

  localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, BRANCH = 3'd2,
                         CALL = 3'd3, RET = 3'd4, SKIP = 3'd5;

  pc_stack_unit dut (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .update_pc(update_pc),
    .op(op),
    .jump_addr(jump_addr),
    .rel_offset(rel_offset),
    .PC(PC),
    .stack_depth(stack_depth),
    .stack_full(stack_full),
    .stack_empty(stack_empty),
    .stack_overflow(stack_overflow),
    .stack_underflow(stack_underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one set of inputs, let one rising edge consume them, sample 1 time unit later.
  task automatic applyStimulus(input logic upd, input logic [2:0] o,
                               input logic [13:0] addr, input logic [7:0] off);
    update_pc  = upd;
    op         = o;
    jump_addr  = addr;
    rel_offset = off;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [13:0] exp_pc,
                             input logic [3:0] exp_depth, input logic exp_ovf,
                             input logic exp_unf);
    tests++;
    assert (PC === exp_pc) else begin
      fails++;
      $error("[TB] FAIL %s PC: got %h expected %h", tag, PC, exp_pc);
    end
    tests++;
    assert (stack_depth === exp_depth) else begin
      fails++;
      $error("[TB] FAIL %s depth: got %0d expected %0d", tag, stack_depth, exp_depth);
    end
    tests++;
    assert (stack_full === (exp_depth == 4'd8)) else begin
      fails++;
      $error("[TB] FAIL %s full: got %b expected %b", tag, stack_full, exp_depth == 4'd8);
    end
    tests++;
    assert (stack_empty === (exp_depth == 4'd0)) else begin
      fails++;
      $error("[TB] FAIL %s empty: got %b expected %b", tag, stack_empty, exp_depth == 4'd0);
    end
    tests++;
    assert (stack_overflow === exp_ovf) else begin
      fails++;
      $error("[TB] FAIL %s overflow: got %b expected %b", tag, stack_overflow, exp_ovf);
    end
    tests++;
    assert (stack_underflow === exp_unf) else begin
      fails++;
      $error("[TB] FAIL %s underflow: got %b expected %b", tag, stack_underflow, exp_unf);
    end
  endtask

  initial begin
    reset      = 1'b0;
    clear      = 1'b0;
    update_pc  = 1'b0;
    op         = NEXT;
    jump_addr  = '0;
    rel_offset = '0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset", 14'd0, 4'd0, 1'b0, 1'b0);
    reset = 1'b1;

    // Sequential fetch
    applyStimulus(1'b1, NEXT, 14'd0, 8'd0);   checkOutput("next1", 14'd1, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, NEXT, 14'd0, 8'd0);   checkOutput("next2", 14'd2, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, NEXT, 14'd0, 8'd0);   checkOutput("next3", 14'd3, 4'd0, 1'b0, 1'b0);

    // Jumps, wrap, relative branches, skip and reserved op
    applyStimulus(1'b1, JUMP, 14'd100, 8'd0);     checkOutput("jump100", 14'd100, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, BRANCH, 14'd0, 8'd5);     checkOutput("br_pos", 14'd105, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, BRANCH, 14'd0, 8'd0);     checkOutput("br_zero", 14'd105, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd6, 14'h1234, 8'd0);    checkOutput("rsv6", 14'd106, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd7, 14'h1234, 8'd0);    checkOutput("rsv7", 14'd107, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, JUMP, 14'h3FFE, 8'd0);    checkOutput("jump_top", 14'h3FFE, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, NEXT, 14'd0, 8'd0);       checkOutput("next_top", 14'h3FFF, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, NEXT, 14'd0, 8'd0);       checkOutput("wrap", 14'h0000, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, BRANCH, 14'd0, 8'hFC);    checkOutput("br_neg", 14'h3FFC, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, SKIP, 14'd0, 8'd0);       checkOutput("skip", 14'h3FFE, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, SKIP, 14'd0, 8'd0);       checkOutput("skip_wrap", 14'h0000, 4'd0, 1'b0, 1'b0);

    // Nested call/return, including CALL immediately followed by RET
    applyStimulus(1'b1, JUMP, 14'd10, 8'd0);      checkOutput("jump10", 14'd10, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, CALL, 14'd200, 8'd0);     checkOutput("call200", 14'd200, 4'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, CALL, 14'd300, 8'd0);     checkOutput("call300", 14'd300, 4'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, RET, 14'd0, 8'd0);        checkOutput("ret201", 14'd201, 4'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, RET, 14'd0, 8'd0);        checkOutput("ret11", 14'd11, 4'd0, 1'b0, 1'b0);

    // Overflow and underflow: every call to 50 from 50 pushes 51
    applyStimulus(1'b1, JUMP, 14'd50, 8'd0);      checkOutput("jump50", 14'd50, 4'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, CALL, 14'd50, 8'd0);
      checkOutput("call_fill", 14'd50, 4'(i), 1'b0, 1'b0);
    end
    applyStimulus(1'b1, CALL, 14'd50, 8'd0);      checkOutput("call_ovf", 14'd50, 4'd8, 1'b1, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(1'b1, RET, 14'd0, 8'd0);
      checkOutput("ret_drain", 14'd51, 4'(i), 1'b1, 1'b0);
    end
    applyStimulus(1'b1, RET, 14'd0, 8'd0);        checkOutput("ret_unf", 14'd52, 4'd0, 1'b1, 1'b1);

    // Strobe low holds everything; clear beats a CALL and wipes sticky flags
    applyStimulus(1'b1, CALL, 14'd400, 8'd0);     checkOutput("call400", 14'd400, 4'd1, 1'b1, 1'b1);
    applyStimulus(1'b0, JUMP, 14'd77, 8'd0);      checkOutput("hold_jump", 14'd400, 4'd1, 1'b1, 1'b1);
    applyStimulus(1'b0, CALL, 14'd77, 8'd0);      checkOutput("hold_call", 14'd400, 4'd1, 1'b1, 1'b1);
    applyStimulus(1'b0, RET, 14'd77, 8'd0);       checkOutput("hold_ret", 14'd400, 4'd1, 1'b1, 1'b1);
    clear = 1'b1;
    applyStimulus(1'b1, CALL, 14'd99, 8'd0);      checkOutput("clear", 14'd0, 4'd0, 1'b0, 1'b0);
    clear = 1'b0;
    applyStimulus(1'b1, RET, 14'd0, 8'd0);        checkOutput("clear_unf", 14'd1, 4'd0, 1'b0, 1'b1);
    clear = 1'b1;
    applyStimulus(1'b0, NEXT, 14'd0, 8'd0);       checkOutput("clear2", 14'd0, 4'd0, 1'b0, 1'b0);
    clear = 1'b0;

    // Asynchronous reset between edges abandons the stack
    applyStimulus(1'b1, CALL, 14'd10, 8'd0);      checkOutput("a_call1", 14'd10, 4'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, CALL, 14'd20, 8'd0);      checkOutput("a_call2", 14'd20, 4'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, CALL, 14'h123, 8'd0);     checkOutput("a_call3", 14'h123, 4'd3, 1'b0, 1'b0);
    update_pc = 1'b0;
    reset = 1'b0;
    #2;
    checkOutput("async_rst", 14'd0, 4'd0, 1'b0, 1'b0);
    reset = 1'b1;
    applyStimulus(1'b1, RET, 14'd0, 8'd0);        checkOutput("post_rst_unf", 14'd1, 4'd0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
